// File: rtl/hex_record_uart_tx.sv
// Serialises one record of NUM_FIELDS fixed-width fields as ASCII hex over a UART line,
// fields separated by SEP_CHAR and terminated by LF or CRLF.
module hex_record_uart_tx #(
    parameter int         CLK_DIV    = 104,
    parameter int         FIELD_W    = 256,
    parameter int         NUM_FIELDS = 2,
    parameter logic [7:0] SEP_CHAR   = 8'h3A,
    parameter bit         CRLF       = 1'b0,
    parameter int         STOP_BITS  = 1,
    parameter bit         LOWERCASE  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rec_valid,
    output logic                          rec_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] rec_data,
    output logic                          txd,
    output logic                          busy,
    output logic [31:0]                   rec_count
);
    localparam int REC_W  = NUM_FIELDS * FIELD_W;
    localparam int DIGITS = FIELD_W / 4;
    localparam int NDIG   = NUM_FIELDS * DIGITS;
    localparam int NBODY  = NDIG + NUM_FIELDS - 1;
    localparam int NCHAR  = NBODY + 1 + (CRLF ? 1 : 0);
    localparam int CI_W   = $clog2(NCHAR + 1);
    localparam int DG_W   = $clog2(NDIG + 1);
    localparam int PS_W   = $clog2(DIGITS + 1);

    localparam logic [CI_W-1:0] TERM_IDX  = CI_W'(NBODY);
    localparam logic [CI_W-1:0] LAST_IDX  = CI_W'(NCHAR - 1);
    localparam logic [PS_W-1:0] SEP_POS   = PS_W'(DIGITS);
    localparam logic [15:0]     BAUD_LOAD = 16'(CLK_DIV - 1);
    localparam logic            STOP_LAST = (STOP_BITS == 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [CI_W-1:0]  char_idx_q, char_idx_d;
    logic [DG_W-1:0]  dig_q, dig_d;
    logic [PS_W-1:0]  pos_q, pos_d;
    logic [REC_W-1:0] rec_q, rec_d;
    logic             txd_q, txd_d;
    logic [31:0]      count_q, count_d;

    logic [3:0] nib_arr [2**DG_W];
    logic [3:0] nib_sel;
    logic [7:0] ascii_digit;
    logic [7:0] char_byte;

    // Flat nibble table, MSB nibble of field 0 first; padded so the index width is exact.
    for (genvar gi = 0; gi < 2**DG_W; gi++) begin : g_nib
        if (gi < NDIG) begin : g_live
            assign nib_arr[gi] = rec_q[REC_W-1-4*gi -: 4];
        end else begin : g_pad
            assign nib_arr[gi] = 4'h0;
        end
    end

    assign nib_sel     = nib_arr[dig_q];
    assign ascii_digit = (nib_sel < 4'd10) ? (8'h30 + {4'h0, nib_sel})
                                           : ((LOWERCASE ? 8'h57 : 8'h37) + {4'h0, nib_sel});

    always_comb begin
        char_byte = ascii_digit;
        if (char_idx_q == TERM_IDX) begin
            char_byte = CRLF ? 8'h0D : 8'h0A;
        end else if (char_idx_q > TERM_IDX) begin
            char_byte = 8'h0A;
        end else if (pos_q == SEP_POS) begin
            char_byte = SEP_CHAR;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        char_idx_d = char_idx_q;
        dig_d      = dig_q;
        pos_d      = pos_q;
        rec_d      = rec_q;
        txd_d      = txd_q;
        count_d    = count_q;
        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (rec_valid) begin
                    rec_d      = rec_data;
                    state_d    = S_START;
                    txd_d      = 1'b0;
                    baud_d     = BAUD_LOAD;
                    char_idx_d = '0;
                    dig_d      = '0;
                    pos_d      = '0;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    txd_d   = char_byte[0];
                    baud_d  = BAUD_LOAD;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = BAUD_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = char_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                if (baud_q == 16'd0) begin
                    baud_d = BAUD_LOAD;
                    if (stop_q == STOP_LAST) begin
                        if (char_idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                            count_d = count_q + 32'd1;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            state_d    = S_START;
                            txd_d      = 1'b0;
                            char_idx_d = char_idx_q + CI_W'(1);
                            if (pos_q == SEP_POS) begin
                                pos_d = '0;
                            end else if (char_idx_q < TERM_IDX) begin
                                pos_d = pos_q + PS_W'(1);
                                dig_d = dig_q + DG_W'(1);
                            end
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            char_idx_q <= '0;
            dig_q      <= '0;
            pos_q      <= '0;
            rec_q      <= '0;
            txd_q      <= 1'b1;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            char_idx_q <= char_idx_d;
            dig_q      <= dig_d;
            pos_q      <= pos_d;
            rec_q      <= rec_d;
            txd_q      <= txd_d;
            count_q    <= count_d;
        end
    end

    assign rec_ready = (state_q == S_IDLE);
    assign busy      = ~rec_ready;
    assign txd       = txd_q;
    assign rec_count = count_q;

endmodule
